// File: rtl/synapse_array_ctrl.sv
// Synapse array controller: sequences fixed-length spiking windows and double-buffers
// weight/threshold configuration so active values only change on window boundaries.
package neuron_pkg;
  typedef logic [7:0] weight_t;
endpackage

module synapse_array_ctrl
  import neuron_pkg::*;
#(
  parameter int NUM_SYN    = 8,
  parameter int WINDOW_LEN = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic                       cfg_sel_thresh,
  input  logic [$clog2(NUM_SYN)-1:0] cfg_addr,
  input  weight_t                    cfg_data,
  output weight_t [NUM_SYN-1:0]      weight_o,
  output weight_t                    threshold_o,
  output logic                       syn_clear,
  output logic                       win_start,
  output logic                       win_end,
  output logic [15:0]                win_count,
  output logic                       busy,
  output logic                       cfg_pending
);

  localparam int              CW   = $clog2(WINDOW_LEN);
  localparam logic [CW-1:0]   LAST = CW'(WINDOW_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP_PEND} state_t;

  state_t                r_state, w_next;
  logic                  r_live;
  logic [CW-1:0]         r_cyc;
  logic [15:0]           r_win_count;
  weight_t [NUM_SYN-1:0] r_weight, r_shadow_w;
  weight_t               r_thresh, r_shadow_t;
  logic                  r_pending;
  logic                  w_last, w_accept, w_wr_ok;

  assign w_last = (r_cyc == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: default assignment first keeps this combinational block free of inferred latches.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (enable && r_live) w_next = S_RUN;
      S_RUN:       if (!enable)          w_next = w_last ? S_IDLE : S_STOP_PEND;
      S_STOP_PEND: begin
        if (enable)      w_next = S_RUN;
        else if (w_last) w_next = S_IDLE;
      end
      default:     w_next = S_IDLE;
    endcase
  end

  // r_live holds cfg_ready and window entry low until the first edge after reset release.
  always_comb begin
    busy      = (r_state != S_IDLE);
    win_start = busy && (r_cyc == '0);
    win_end   = busy && w_last;
    syn_clear = ((r_state == S_IDLE) && enable && r_live) || win_end;
    cfg_ready = r_live && !win_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live      <= 1'b0;
      r_cyc       <= '0;
      r_win_count <= '0;
    end else begin
      r_live <= 1'b1;
      if (r_state == S_IDLE || w_last) r_cyc <= '0;
      else                             r_cyc <= r_cyc + 1'b1;
      if (win_end) r_win_count <= r_win_count + 16'd1;
    end
  end

  assign w_accept = cfg_valid && cfg_ready;
  assign w_wr_ok  = cfg_sel_thresh || (int'(cfg_addr) < NUM_SYN);

  // NOTE: active and shadow banks are reset explicitly because downstream synapses rely on zeroed weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weight   <= '0;
      r_shadow_w <= '0;
      r_thresh   <= '0;
      r_shadow_t <= '0;
      r_pending  <= 1'b0;
    end else if (win_end) begin
      if (r_pending) begin
        r_weight  <= r_shadow_w;
        r_thresh  <= r_shadow_t;
        r_pending <= 1'b0;
      end
    end else if (w_accept && w_wr_ok) begin
      // Shadow always takes the write so it keeps mirroring active plus queued updates.
      if (cfg_sel_thresh) r_shadow_t           <= cfg_data;
      else                r_shadow_w[cfg_addr] <= cfg_data;
      if (r_state == S_IDLE) begin
        if (cfg_sel_thresh) r_thresh           <= cfg_data;
        else                r_weight[cfg_addr] <= cfg_data;
      end else begin
        r_pending <= 1'b1;
      end
    end
  end

  assign weight_o    = r_weight;
  assign threshold_o = r_thresh;
  assign win_count   = r_win_count;
  assign cfg_pending = r_pending;

endmodule

// File: tb/tb_synapse_array_ctrl.sv
// Self-checking bench for synapse_array_ctrl: directed window/config sequences plus
// randomized traffic compared against a window-position reference model.
module tb_synapse_array_ctrl;
  import neuron_pkg::*;

  localparam int NS = 6;
  localparam int WL = 48;
  localparam int AW = $clog2(NS);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_sel_thresh = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  weight_t          cfg_data = '0;
  logic             cfg_ready, syn_clear, win_start, win_end, busy, cfg_pending;
  weight_t [NS-1:0] weight_o;
  weight_t          threshold_o;
  logic [15:0]      win_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  synapse_array_ctrl #(.NUM_SYN(NS), .WINDOW_LEN(WL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel_thresh(cfg_sel_thresh),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .weight_o(weight_o), .threshold_o(threshold_o),
    .syn_clear(syn_clear), .win_start(win_start), .win_end(win_end),
    .win_count(win_count), .busy(busy), .cfg_pending(cfg_pending)
  );

  // Reference model: "in a window at position m_pos" plus two register banks.
  bit m_live, m_busy, m_pend;
  int m_pos, m_wcnt, m_thr, m_shthr;
  int m_act[NS];
  int m_sh[NS];

  task automatic model_reset();
    m_live = 0; m_busy = 0; m_pend = 0;
    m_pos = 0; m_wcnt = 0; m_thr = 0; m_shthr = 0;
    for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_sh[i] = 0; end
  endtask

  function automatic logic [5:0] model_flags();
    logic we, ws, clr, rdy;
    we  = m_busy && (m_pos == WL - 1);
    ws  = m_busy && (m_pos == 0);
    clr = (!m_busy && enable && m_live) || we;
    rdy = m_live && !we;
    return {clr, ws, we, m_busy, m_pend, rdy};
  endfunction

  function automatic logic [NS*8-1:0] pack_act();
    logic [NS*8-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) r[i*8 +: 8] = 8'(m_act[i]);
    return r;
  endfunction

  task automatic model_step();
    bit we, rdy;
    we  = m_busy && (m_pos == WL - 1);
    rdy = m_live && !we;
    if (we) begin
      m_wcnt = (m_wcnt + 1) % 65536;
      if (m_pend) begin
        m_act = m_sh; m_thr = m_shthr; m_pend = 0;
      end
    end else if (cfg_valid && rdy && (cfg_sel_thresh || int'(cfg_addr) < NS)) begin
      if (cfg_sel_thresh) m_shthr = int'(cfg_data);
      else                m_sh[cfg_addr] = int'(cfg_data);
      if (!m_busy) begin
        if (cfg_sel_thresh) m_thr = int'(cfg_data);
        else                m_act[cfg_addr] = int'(cfg_data);
      end else begin
        m_pend = 1;
      end
    end
    if (!m_busy) begin
      if (enable && m_live) begin m_busy = 1; m_pos = 0; end
    end else if (m_pos == WL - 1) begin
      m_pos = 0; m_busy = enable;
    end else begin
      m_pos++;
    end
    m_live = 1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic look();
    #1;
  endtask

  // Entered 1ns after a rising edge with inputs applied; compares against the model, then clocks it.
  task automatic tick();
    #1;
    check("flags", 64'({syn_clear, win_start, win_end, busy, cfg_pending, cfg_ready}), 64'(model_flags()));
    check("win_count", 64'(win_count), 64'(m_wcnt[15:0]));
    check("threshold", 64'(threshold_o), 64'(m_thr[7:0]));
    check("weights", 64'(weight_o), 64'(pack_act()));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_until_idle();
    int n;
    enable = 1'b0; cfg_valid = 1'b0;
    for (n = 0; n < 4 * WL; n++) begin
      look();
      if (!busy) break;
      tick();
    end
    check("idle_reached", 64'(busy), 64'(0));
  endtask

  typedef struct {
    logic             sel;
    logic [AW-1:0]    addr;
    weight_t          data;
    logic [NS*8-1:0]  exp_w;
    weight_t          exp_t;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int k, w;
    vecs[0] = '{1'b0, 3'd3, 8'h25, 48'h0000_2500_0000, 8'h00};
    vecs[1] = '{1'b1, 3'd0, 8'h10, 48'h0000_2500_0000, 8'h10};
    vecs[2] = '{1'b0, 3'd0, 8'hA1, 48'h0000_2500_00A1, 8'h10};
    vecs[3] = '{1'b0, 3'd6, 8'hFF, 48'h0000_2500_00A1, 8'h10};
    vecs[4] = '{1'b0, 3'd7, 8'h77, 48'h0000_2500_00A1, 8'h10};
    vecs[5] = '{1'b0, 3'd5, 8'h3C, 48'h3C00_2500_00A1, 8'h10};
    vecs[6] = '{1'b0, 3'd3, 8'h26, 48'h3C00_2600_00A1, 8'h10};
    vecs[7] = '{1'b1, 3'd5, 8'h99, 48'h3C00_2600_00A1, 8'h99};

    // Reset state, with enable high to show syn_clear stays quiet under reset.
    model_reset();
    enable = 1'b1;
    #2;
    check("rst_flags", 64'({syn_clear, win_start, win_end, busy, cfg_pending, cfg_ready}), 64'(0));
    check("rst_weights", 64'(weight_o), 64'(0));
    check("rst_count", 64'(win_count), 64'(0));
    enable = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // First window: enable at cycle 5.
    for (int c = 0; c < 56; c++) begin
      enable = (c >= 5);
      look();
      check("a_syn_clear", 64'(syn_clear), 64'(c == 5 || c == 53));
      check("a_win_start", 64'(win_start), 64'(c == 6 || c == 54));
      check("a_win_end",   64'(win_end),   64'(c == 53));
      check("a_win_count", 64'(win_count), 64'(c >= 54));
      check("a_cfg_ready", 64'(cfg_ready), 64'(c != 0 && c != 53));
      tick();
    end
    run_until_idle();

    // Idle configuration writes take effect on the accepting edge.
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1; cfg_sel_thresh = vecs[i].sel;
      cfg_addr = vecs[i].addr; cfg_data = vecs[i].data;
      tick();
      cfg_valid = 1'b0;
      look();
      check("tbl_weights", 64'(weight_o), 64'(vecs[i].exp_w));
      check("tbl_thresh",  64'(threshold_o), 64'(vecs[i].exp_t));
      check("tbl_pending", 64'(cfg_pending), 64'(0));
    end

    // Mid-window writes, commit on window end, blocked write during win_end, stop cancel.
    enable = 1'b1;
    look();
    check("c_syn_clear", 64'(syn_clear), 64'(1));
    tick();
    for (int n = 0; n < 5 * WL; n++) begin
      k = n % WL; w = n / WL;
      cfg_valid      = (w == 0 && k == 10) || (w == 1 && k == WL - 1) || (w == 2 && k == 0);
      cfg_sel_thresh = (w == 0);
      cfg_addr       = 3'd2;
      cfg_data       = (w == 0) ? 8'h10 : 8'h5A;
      enable         = (w < 3) || (w == 3 && (k < 20 || k >= 30)) || (w == 4 && k < 20);
      look();
      check("c_win_start", 64'(win_start), 64'(k == 0));
      check("c_win_end",   64'(win_end),   64'(k == WL - 1));
      check("c_busy",      64'(busy),      64'(1));
      check("c_cfg_ready", 64'(cfg_ready), 64'(k != WL - 1));
      check("c_thresh",    64'(threshold_o), 64'((w == 0) ? 8'h99 : 8'h10));
      check("c_pending",   64'(cfg_pending), 64'((w == 0 && k >= 11) || (w == 2 && k >= 1)));
      check("c_weight2",   64'(weight_o[2]), 64'((w < 3) ? 8'h00 : 8'h5A));
      tick();
    end
    cfg_valid = 1'b0; enable = 1'b0;
    look();
    check("c_idle_busy",  64'(busy), 64'(0));
    check("c_idle_start", 64'(win_start), 64'(0));
    check("c_idle_count", 64'(win_count), 64'(7));

    // Reset mid-window with a pending shadow write.
    enable = 1'b1;
    tick();
    for (int n = 0; n < 25; n++) begin
      cfg_valid = (n == 5); cfg_sel_thresh = 1'b0; cfg_addr = 3'd1; cfg_data = 8'h44;
      tick();
    end
    cfg_valid = 1'b0;
    look();
    check("f_pending_before", 64'(cfg_pending), 64'(1));
    rst_n = 1'b0;
    #1;
    check("f_rst_flags", 64'({syn_clear, win_start, win_end, busy, cfg_pending, cfg_ready}), 64'(0));
    check("f_rst_weights", 64'(weight_o), 64'(0));
    check("f_rst_thresh", 64'(threshold_o), 64'(0));
    check("f_rst_count", 64'(win_count), 64'(0));
    model_reset();
    enable = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    look();
    check("f_ready_low", 64'(cfg_ready), 64'(0));
    tick();
    look();
    check("f_ready_high", 64'(cfg_ready), 64'(1));
    check("f_weights_zero", 64'(weight_o), 64'(0));

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15) == 0) enable = ~enable;
      cfg_valid      = ($urandom_range(2) == 0);
      cfg_sel_thresh = ($urandom_range(3) == 0);
      cfg_addr       = AW'($urandom_range(7));
      cfg_data       = 8'($urandom);
      tick();
    end
    run_until_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/synapse_array_ctrl.md
SYNAPSE_ARRAY_CTRL -- requirements
Module: synapse_array_ctrl

Interface
REQ-001 Parameter NUM_SYN, default 8, number of synapses configured and sequenced (2..64).
REQ-002 Parameter WINDOW_LEN, default 48, spiking-window length in clk cycles (2..1024).
REQ-003 clk  input  1  rising-edge clock, sole clock of block.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  level request to run windows.
REQ-006 cfg_valid  input  1  config write request.
REQ-007 cfg_ready  output  1  config write accepted when cfg_valid and cfg_ready both high on a rising edge.
REQ-008 cfg_sel_thresh  input  1  1 = write threshold, 0 = write weight[cfg_addr].
REQ-009 cfg_addr  input  clog2(NUM_SYN)  weight index; ignored when cfg_sel_thresh=1.
REQ-010 cfg_data  input  weight_t (neuron_pkg)  value written.
REQ-011 weight_o  output  NUM_SYN x weight_t  active weights driven to synapse array.
REQ-012 threshold_o  output  weight_t  active threshold driven to all synapses.
REQ-013 syn_clear  output  1  one-cycle pulse clearing synapse accumulators.
REQ-014 win_start / win_end  output  1 each  one-cycle pulses on first / last cycle of each window.
REQ-015 win_count  output  16  completed-window count, wraps 0xFFFF->0.
REQ-016 busy  output  1  high in RUN or STOP_PEND.
REQ-017 cfg_pending  output  1  shadow holds uncommitted writes.

Function
REQ-018 FSM states SHALL be IDLE, RUN, STOP_PEND; cycle counter cyc counts 0..WINDOW_LEN-1 in RUN/STOP_PEND, held 0 in IDLE.
REQ-019 IDLE->RUN when enable=1; that transition cycle asserts syn_clear, and the first RUN cycle (cyc=0) asserts win_start.
REQ-020 RUN: cyc increments each cycle; at cyc=WINDOW_LEN-1 win_end=1, cyc wraps to 0, win_count increments, next cycle win_start=1.
REQ-021 RUN->STOP_PEND when enable=0 and cyc!=WINDOW_LEN-1; enable=0 at cyc=WINDOW_LEN-1 goes directly to IDLE after window end.
REQ-022 STOP_PEND->RUN when enable returns to 1 before window end (stop cancelled, cyc continues); STOP_PEND->IDLE at cyc=WINDOW_LEN-1 with win_end=1 and win_count increment.
REQ-023 syn_clear SHALL also pulse on every win_end cycle (same cycle as win_end).
REQ-024 Writes in IDLE SHALL update active registers (weight_o/threshold_o) on the accepting edge; cfg_pending stays 0.
REQ-025 Writes in RUN/STOP_PEND SHALL update a shadow copy only and set cfg_pending; active outputs unchanged mid-window.
REQ-026 On each win_end cycle with cfg_pending=1, the full shadow SHALL be copied into active registers at that edge and cfg_pending cleared; new values visible from win_start cycle.
REQ-027 cfg_ready SHALL be 1 except during the win_end cycle (commit cycle), where it is 0.
REQ-028 Shadow SHALL mirror active registers after every IDLE write and every commit, so partial updates keep unwritten entries.
REQ-029 Multiple writes to the same entry within one window: last accepted write wins.
REQ-030 cfg_addr >= NUM_SYN with cfg_sel_thresh=0 SHALL be accepted and discarded (no register change, cfg_pending unchanged).
REQ-031 win_start and win_end SHALL never assert in IDLE; with WINDOW_LEN=2 they alternate every cycle.

Reset
REQ-032 rst_n low SHALL asynchronously force: state IDLE, cyc=0, all weights/shadow=0, threshold=0, win_count=0, cfg_pending=0, syn_clear/win_start/win_end/busy=0, cfg_ready=0.
REQ-033 cfg_ready SHALL rise on the first clock edge after rst_n release; reset mid-window discards pending shadow writes.

Verification
REQ-034 Reset, enable=1 at cycle 5, WINDOW_LEN=48 -> syn_clear at 5, win_start at 6, win_end at 53, win_count=1 at 54, win_start at 54.
REQ-035 IDLE write addr=3 data=0x25 -> weight_o[3]=0x25 next cycle, cfg_pending=0.
REQ-036 RUN, write thresh=0x10 at cyc=10 -> threshold_o unchanged until win_end edge, then 0x10; cfg_pending 1 from cyc 11 to window end.
REQ-037 cfg_valid held high through win_end cycle -> cfg_ready=0 that cycle, write accepted next cycle into shadow for following window.
REQ-038 enable drops at cyc=20, rises at cyc=30 -> STOP_PEND then RUN, no gap; enable drops at cyc=20 and stays low -> IDLE after win_end at cyc=47, busy=0.
REQ-039 rst_n asserted at cyc=25 with cfg_pending=1 -> all outputs zero immediately; after release active weights zero.
